// File: rtl/dma_write_arbiter.sv
// dma_write_arbiter: two-requester write arbiter feeding a DMA UART engine.
// Accepted requests are queued in a DEPTH-entry FIFO of {addr, data} and issued
// to the engine in acceptance order, one write strobe at a time.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   reqN_valid/ready         requester handshake (N = 0, 1), accept on valid && ready
//   reqN_addr/data           requester write address and data
//   dma_dat_addr, dma_dat_w  registered address/data to the engine
//   we                       one-cycle write strobe to the engine
//   busy                     engine busy flag
//   pending                  queued, not-yet-issued entries
//   idle                     FSM idle and queue empty
//   timeout_err              sticky: engine never raised busy after a strobe
module dma_write_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [ADDR_W-1:0]          req0_addr,
  input  logic [DATA_W-1:0]          req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [ADDR_W-1:0]          req1_addr,
  input  logic [DATA_W-1:0]          req1_data,
  output logic [ADDR_W-1:0]          dma_dat_addr,
  output logic [DATA_W-1:0]          dma_dat_w,
  output logic                       we,
  input  logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       idle,
  output logic                       timeout_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  logic [EntW-1:0]   mem_q [DEPTH];
  logic [EntW-1:0]   mem_d [DEPTH];
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic              full, empty;
  logic              prio_q, prio_d;
  logic              push0, push1, push, pop;
  logic [EntW-1:0]   push_entry, head;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [1:0]        to_cnt_q, to_cnt_d;

  // Extra pointer bit separates full from empty when the index bits match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // A requester is refused only when the other one holds the grant; with no
  // valid at all both readies stay high. Readies drop during reset.
  assign req0_ready = reset & ~full & (~req1_valid | (req0_valid & ~prio_q));
  assign req1_ready = reset & ~full & (~req0_valid | (req1_valid & prio_q));

  assign push0      = req0_valid & req0_ready;
  assign push1      = req1_valid & req1_ready;
  assign push       = push0 | push1;
  assign push_entry = push0 ? {req0_addr, req0_data} : {req1_addr, req1_data};
  assign head       = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !busy) begin
          state_d = StIssue;
          we_d    = 1'b1;
          addr_d  = head[EntW-1:DATA_W];
          data_d  = head[DATA_W-1:0];
        end
      end
      StIssue: begin
        pop      = 1'b1;
        to_cnt_d = 2'd0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (busy) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (!busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    if (push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = push_entry;
      wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
      prio_d   = ~prio_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      prio_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
      mem_q    <= mem_d;
    end
  end

  assign we           = we_q;
  assign dma_dat_addr = addr_q;
  assign dma_dat_w    = data_q;
  assign timeout_err  = err_q;
  assign pending      = count;
  assign idle         = (state_q == StIdle) && empty;

endmodule

// File: tb/tb_dma_write_arbiter.sv
// Directed bench for dma_write_arbiter with a reference model of the
// arbitration/queue occupancy and a scoreboard of expected issued writes.
module tb_dma_write_arbiter;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic [ADDR_W-1:0] dma_dat_addr;
  logic [DATA_W-1:0] dma_dat_w;
  logic              we;
  logic              busy = 1'b0;
  logic [2:0]        pending;
  logic              idle;
  logic              timeout_err;

  always #5 clk = ~clk;

  dma_write_arbiter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .dma_dat_addr(dma_dat_addr),
    .dma_dat_w   (dma_dat_w),
    .we          (we),
    .busy        (busy),
    .pending     (pending),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cnt = 0;
  int last_we_cyc = -1;
  int last_acc_cyc = -1;
  int acc_cnt0 = 0;
  int acc_cnt1 = 0;
  int mcount = 0;
  logic mprio = 1'b0;
  logic [ADDR_W+DATA_W-1:0] sb[$];
  logic [ADDR_W-1:0] issued[$];
  logic [ADDR_W-1:0] exp038[4] = '{7'h01, 7'h41, 7'h02, 7'h42};

  // Engine model: 0 = busy follows busy_force, 1 = busy for eng_len cycles
  // starting the cycle after we, 2 = never busy.
  int eng_mode = 0;
  int eng_len = 20;
  int eng_cnt = 0;
  logic busy_force = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (eng_mode == 1) begin
      if (eng_cnt > 0) begin
        busy = 1'b1;
        eng_cnt--;
      end else begin
        busy = 1'b0;
      end
      if (we) eng_cnt = eng_len;
    end else if (eng_mode == 2) begin
      busy = 1'b0;
    end else begin
      busy = busy_force;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare against the model at the falling edge, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    logic e0, e1, a0, a1;
    logic [ADDR_W+DATA_W-1:0] head_v;
    @(negedge clk);
    cyc++;
    if (reset) begin
      e0 = (mcount < DEPTH) && (!req1_valid || (req0_valid && !mprio));
      e1 = (mcount < DEPTH) && (!req0_valid || (req1_valid && mprio));
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("pending", 32'(pending), 32'(mcount));
      if (we) begin
        we_cnt++;
        last_we_cyc = cyc;
        issued.push_back(dma_dat_addr);
        if (sb.size() == 0) begin
          chk("we_unexpected", 32'(we), 32'(0));
        end else begin
          head_v = sb.pop_front();
          chk("issue_addr", 32'(dma_dat_addr), 32'(head_v[ADDR_W+DATA_W-1:DATA_W]));
          chk("issue_data", 32'(dma_dat_w), 32'(head_v[DATA_W-1:0]));
          mcount--;
        end
      end
      a0 = req0_valid && e0;
      a1 = req1_valid && e1;
      if (a0 || a1) begin
        sb.push_back(a0 ? {req0_addr, req0_data} : {req1_addr, req1_data});
        mcount++;
        mprio = !mprio;
        last_acc_cyc = cyc;
        if (a0) acc_cnt0++;
        else acc_cnt1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(int n, int budget);
    int k = 0;
    while (we_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("we_count", 32'(we_cnt), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    mcount = 0;
    mprio = 1'b0;
    acc_cnt0 = 0;
    acc_cnt1 = 0;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    chk("rst_idle", 32'(idle), 32'(1));
    chk("rst_we", 32'(we), 32'(0));
    chk("rst_pending", 32'(pending), 32'(0));
    chk("rst_addr", 32'(dma_dat_addr), 32'(0));
    chk("rst_data", 32'(dma_dat_w), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int a_cyc, k, base, fw, acc5;
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_cyc, k, base, fw, acc5;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset, no requests.
    step();
    chk("idle_after_rst", 32'(idle), 32'(1));
    chk("we_after_rst", 32'(we), 32'(0));
    chk("err_after_rst", 32'(timeout_err), 32'(0));

    // Single write, engine goes busy for 20 cycles after the strobe.
    eng_len = 20;
    eng_cnt = 0;
    eng_mode = 1;
    req0_valid = 1'b1;
    req0_addr = 7'h19;
    req0_data = 18'h35D15;
    step();
    a_cyc = last_acc_cyc;
    req0_valid = 1'b0;
    wait_we(1, 10);
    chk("latency", 32'(last_we_cyc), 32'(a_cyc + 2));
    k = last_we_cyc;
    while (cyc < k + 20) step();
    chk("idle_while_busy", 32'(idle), 32'(0));
    step();
    chk("idle_after_busy", 32'(idle), 32'(1));
    chk("addr_held", 32'(dma_dat_addr), 32'h19);
    chk("data_held", 32'(dma_dat_w), 32'h35D15);
    chk("single_we", 32'(we_cnt), 32'(1));

    // Both requesters valid: alternation starting from requester 0.
    do_reset();
    issued.delete();
    eng_len = 2;
    eng_cnt = 0;
    eng_mode = 1;
    base = we_cnt;
    for (int i = 0; i < 6; i++) begin
      req0_valid = (acc_cnt0 < 2);
      req0_addr = 7'(1 + acc_cnt0);
      req0_data = 18'(18'h00100 + acc_cnt0);
      req1_valid = (acc_cnt1 < 2);
      req1_addr = 7'(8'h41 + acc_cnt1);
      req1_data = 18'(18'h00200 + acc_cnt1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_we(base + 4, 60);
    chk("rr_issue_cnt", 32'(issued.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < issued.size()) chk("rr_order", 32'(issued[i]), 32'(exp038[i]));
    end

    // Engine held busy: queue fills to DEPTH, fifth write waits for a slot.
    eng_mode = 0;
    busy_force = 1'b1;
    step();
    acc_cnt0 = 0;
    base = we_cnt;
    issued.delete();
    for (int i = 0; i < 8; i++) begin
      req0_valid = (acc_cnt0 < 5);
      req0_addr = 7'(8'h10 + acc_cnt0);
      req0_data = 18'(18'h2A000 + acc_cnt0);
      step();
    end
    chk("full_ready", 32'(req0_ready), 32'(0));
    chk("full_pending", 32'(pending), 32'(4));
    chk("no_issue_busy", 32'(we_cnt), 32'(base));
    eng_cnt = 0;
    eng_len = 2;
    eng_mode = 1;
    fw = -1;
    acc5 = -1;
    for (int i = 0; i < 80 && we_cnt < base + 5; i++) begin
      step();
      if (fw < 0 && we_cnt == base + 1) fw = last_we_cyc;
      if (acc5 < 0 && acc_cnt0 == 5) acc5 = last_acc_cyc;
      req0_valid = (acc_cnt0 < 5);
      req0_addr = 7'(8'h10 + acc_cnt0);
      req0_data = 18'(18'h2A000 + acc_cnt0);
    end
    req0_valid = 1'b0;
    chk("fifth_accept", 32'(acc5), 32'(fw + 1));
    chk("stream_issue_cnt", 32'(we_cnt), 32'(base + 5));
    if (issued.size() == 5) chk("fifth_addr", 32'(issued[4]), 32'h14);
    repeat (6) step();
    chk("no_err_yet", 32'(timeout_err), 32'(0));

    // Engine never responds: timeout, then the next entry still issues.
    eng_mode = 2;
    base = we_cnt;
    req0_valid = 1'b1;
    req0_addr = 7'h30;
    req0_data = 18'h00030;
    step();
    req0_addr = 7'h31;
    req0_data = 18'h00031;
    step();
    req0_valid = 1'b0;
    wait_we(base + 1, 10);
    k = last_we_cyc;
    while (cyc < k + 3) step();
    chk("err_before_to", 32'(timeout_err), 32'(0));
    step();
    chk("err_after_to", 32'(timeout_err), 32'(1));
    wait_we(base + 2, 10);
    chk("issue_after_to", 32'(last_we_cyc), 32'(k + 6));
    repeat (8) step();
    chk("err_sticky", 32'(timeout_err), 32'(1));

    // Reset while in WAIT_DONE with three entries still queued.
    eng_cnt = 0;
    eng_len = 30;
    eng_mode = 1;
    acc_cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = (acc_cnt0 < 4);
      req0_addr = 7'(8'h50 + acc_cnt0);
      req0_data = 18'(18'h15000 + acc_cnt0);
      step();
    end
    req0_valid = 1'b0;
    step();
    chk("pre_rst_pending", 32'(pending), 32'(3));
    chk("pre_rst_busy_wait", 32'(idle), 32'(0));
    req0_valid = 1'b1;
    req0_addr = 7'h5F;
    eng_mode = 0;
    busy_force = 1'b0;
    base = we_cnt;
    do_reset();
    repeat (10) step();
    chk("no_we_after_rst", 32'(we_cnt), 32'(base));
    chk("idle_after_flush", 32'(idle), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
